rx_deformatter: RTL

// - Receive-side counterpart of the CPPF TX formatter/CRC stage. Runs in clk_250 on the link's 32-bit word + 4-bit K stream.
// - Strips padding, locks to the orbit trailer, extracts link ID and CRC word, and rebuilds three 64-bit frames per BX.
// - Feeds the EMTF input deserializer/BX-alignment logic; the CRC word goes to a separate checker.

---
 rtl/rx_deformatter.sv | 100 ++++++++++
 1 files changed

// File: rtl/rx_deformatter.sv
// rx_deformatter: strips padding, locks to the orbit trailer, extracts CRC/link ID
// and rebuilds three 64-bit frames per BX from the 32-bit word + K stream.
module rx_deformatter #(
   parameter int          PAYLOAD_BX = 3559,
   parameter logic [31:0] COMMA_WORD = 32'h505050bc,
   parameter logic [31:0] PAD_WORD   = 32'hf7f7f7f7,
   parameter int          ERR_W      = 16
) (
   input  logic             clk_250,
   input  logic             rst,
   input  logic [31:0]      rxdata,
   input  logic [3:0]       rxcharisk,
   output logic [2:0][63:0] frames,
   output logic             frames_valid,
   output logic [11:0]      payload_bx,
   output logic [19:0]      link_id,
   output logic             link_id_valid,
   output logic [31:0]      crc_word,
   output logic             crc_valid,
   output logic             locked,
   output logic [ERR_W-1:0] framing_err_cnt,
   output logic [ERR_W-1:0] bxcount_err_cnt
);
   typedef enum logic [2:0] {HUNT, TRL_CRC, TRL_LID, TRL_END, COMMAS, PAYLOAD} state_t;
   localparam logic [11:0]      PBX     = 12'(PAYLOAD_BX);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   state_t          state, state_nxt;
   logic [2:0]      widx, wi;
   logic [4:0][31:0] wbuf;
   logic [11:0]     bx_cnt;
   logic            is_pad, is_comma, is_data, is_bad;
   logic            crc_ld, lid_ld, lock_set, wr, bx_done, trl_chk, mid_err, bad_err, unlock, bx_clr;
   assign is_pad   = rxcharisk == 4'hf && rxdata == PAD_WORD;
   assign is_comma = rxcharisk == 4'b0001 && rxdata == COMMA_WORD;
   assign is_data  = rxcharisk == 4'h0;
   assign is_bad   = !is_pad && !is_comma && !is_data;
   always_ff @(posedge clk_250)
      state <= rst ? HUNT : state_nxt;
   always_comb begin
      state_nxt = state;
      if (is_bad) state_nxt = HUNT;
      else case (state)
         HUNT:    if (is_comma) state_nxt = TRL_CRC;
         TRL_CRC: if (is_data) state_nxt = TRL_LID;
         TRL_LID: state_nxt = is_data ? TRL_END : is_comma ? TRL_CRC : state;
         TRL_END: state_nxt = is_comma ? COMMAS : is_data ? HUNT : state;
         COMMAS:  if (is_data) state_nxt = PAYLOAD;
         PAYLOAD: if (is_comma) state_nxt = TRL_CRC;
         default: state_nxt = HUNT;
      endcase
   end
   always_comb begin
      crc_ld   = state == TRL_CRC && is_data;
      lid_ld   = state == TRL_LID && is_data;
      lock_set = state == TRL_END && is_comma;
      wr       = (state == COMMAS || state == PAYLOAD) && is_data;
      bx_done  = state == PAYLOAD && is_data && widx == 3'd5;
      trl_chk  = state == PAYLOAD && is_comma && widx == 3'd0;
      mid_err  = state == PAYLOAD && is_comma && widx != 3'd0;
      bad_err  = is_bad && locked;
      unlock   = is_bad || mid_err || (state == TRL_END && is_data);
      bx_clr   = is_comma && (state == HUNT || state == PAYLOAD);
      wi       = state == COMMAS ? 3'd0 : widx;
   end
   // Word 5 is never buffered: it goes straight into frames[2] alongside word 4.
   always_ff @(posedge clk_250) begin
      if (rst) begin
         frames          <= '0;
         frames_valid    <= 1'b0;
         payload_bx      <= '0;
         link_id         <= '0;
         link_id_valid   <= 1'b0;
         crc_word        <= '0;
         crc_valid       <= 1'b0;
         locked          <= 1'b0;
         framing_err_cnt <= '0;
         bxcount_err_cnt <= '0;
         widx            <= '0;
         wbuf            <= '0;
         bx_cnt          <= '0;
      end else begin
         frames_valid <= bx_done;
         crc_valid    <= crc_ld;
         if (crc_ld) crc_word <= rxdata;
         if (lid_ld) link_id <= {rxdata[9:0], rxdata[25:16]};
         if (wr) widx <= state == COMMAS ? 3'd1 : widx == 3'd5 ? 3'd0 : widx + 3'd1;
         if (bx_done) begin
            frames     <= {rxdata, wbuf[4], wbuf[3], wbuf[2], wbuf[1], wbuf[0]};
            payload_bx <= bx_cnt;
         end else if (wr) wbuf[wi] <= rxdata;
         bx_cnt <= bx_clr ? 12'd0 : (bx_done && bx_cnt != 12'hfff) ? bx_cnt + 12'd1 : bx_cnt;
         if (trl_chk && bx_cnt != PBX && bxcount_err_cnt != ERR_MAX)
            bxcount_err_cnt <= bxcount_err_cnt + 1'b1;
         if ((mid_err || bad_err) && framing_err_cnt != ERR_MAX)
            framing_err_cnt <= framing_err_cnt + 1'b1;
         locked        <= lock_set ? 1'b1 : unlock ? 1'b0 : locked;
         link_id_valid <= lock_set ? 1'b1 : bad_err ? 1'b0 : link_id_valid;
      end
   end
endmodule
